// File: rtl/mips32_trace_buffer.sv
// Pipeline trace-capture buffer for the MIPS32 debug probes: records stamped
// per-cycle snapshots while capturing, then drains them oldest-first over valid/ready.
module mips32_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int SAMPLE_LIMIT = 16,
    parameter bit RING_MODE    = 1'b0,
    parameter int STAMP_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     probe_en,
    input  logic [11:0]              ctrl_code,
    input  logic [13:0]              mem_addr,
    input  logic [31:0]              mem_data,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic [31:0]              next_pc,
    input  logic [31:0]              instr_if,
    input  logic [31:0]              instr_id,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [190:0]             rd_entry,
    output logic [STAMP_W-1:0]       rd_stamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     overflow
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int ENTRY_W = 191;
    localparam int SLOT_W  = ENTRY_W + STAMP_W;
    localparam int SCNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [STAMP_W-1:0]  stamp_q, stamp_d;
    logic [SCNT_W-1:0]   sample_q, sample_d;

    logic                mem_we;
    logic [PW-1:0]       mem_waddr;
    logic [SLOT_W-1:0]   mem_wdata;
    logic [SLOT_W-1:0]   mem [DEPTH];
    logic [SLOT_W-1:0]   rd_slot;

    logic                full;
    logic                pop;
    logic [ENTRY_W-1:0]  probe_word;

    assign probe_word = {instr_id, instr_if, next_pc, wb_data, wb_addr,
                         mem_data, mem_addr, ctrl_code};
    assign full       = (count_q == CW'(DEPTH));
    assign rd_valid   = (state_q == ST_DONE) && (count_q != '0);
    assign pop        = rd_valid && rd_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        stamp_d    = stamp_q;
        sample_d   = sample_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q;
        mem_wdata  = {probe_word, stamp_q};

        if (arm) begin
            // arm restarts from any state and takes priority over stop
            state_d    = ST_CAPTURE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            stamp_d    = '0;
            sample_d   = '0;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    stamp_d = stamp_q + STAMP_W'(1);
                    if (probe_en) begin
                        if (RING_MODE) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            if (full) begin
                                // overwrite the oldest slot and slide the window
                                rd_ptr_d   = rd_ptr_q + PW'(1);
                                overflow_d = 1'b1;
                            end else begin
                                count_d = count_q + CW'(1);
                            end
                        end else begin
                            sample_d = sample_q + SCNT_W'(1);
                            if (full) begin
                                overflow_d = 1'b1;
                            end else begin
                                mem_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + PW'(1);
                                count_d  = count_q + CW'(1);
                            end
                            if (sample_d == SCNT_W'(SAMPLE_LIMIT)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                    if (stop) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        count_d  = count_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            stamp_q    <= '0;
            sample_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            stamp_q    <= stamp_d;
            sample_q   <= sample_d;
        end
    end

    // Storage has no reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_slot  = mem[rd_ptr_q];
    assign rd_entry = rd_valid ? rd_slot[SLOT_W-1:STAMP_W] : '0;
    assign rd_stamp = rd_valid ? rd_slot[STAMP_W-1:0] : '0;
    assign count    = count_q;
    assign state    = state_q;
    assign overflow = overflow_q;

endmodule
